// File: rtl/pool_frame_collector.sv
// Collects one pooled frame (FrameSize signed values, raster order) and presents
// it as a single packed word with a valid/ready handshake toward the dense layer.
module pool_frame_collector #(
    parameter int BitSize    = 4,
    parameter int ImageWidth = 6,
    parameter int N          = 2,
    localparam int OutWidth  = ImageWidth / N,
    localparam int FrameSize = OutWidth * OutWidth
) (
    input  logic                          clk,
    input  logic                          res_n,
    input  logic                          in_valid,
    input  logic signed [BitSize-1:0]     in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [FrameSize*BitSize-1:0]  out_data,
    input  logic                          out_ready,
    output logic                          overflow
);

    localparam int CntW = $clog2(FrameSize + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(FrameSize - 1);

    typedef enum logic {COLLECT, PRESENT} state_t;

    state_t                            state_q, state_d;
    logic [CntW-1:0]                   cnt_q;
    logic [FrameSize-1:0][BitSize-1:0] frame_q;
    logic                              in_xfer, out_xfer;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == LastIdx) state_d = PRESENT;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign out_data = frame_q;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_xfer) cnt_q <= (cnt_q == LastIdx) ? '0 : cnt_q + 1'b1;
            else if (out_xfer) cnt_q <= '0;
            // Anything offered while presenting is lost; remember it until reset.
            if (in_valid && !in_ready) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            frame_q <= '0;
        end else begin
            for (int i = 0; i < FrameSize; i++)
                if (in_xfer && cnt_q == CntW'(i)) frame_q[i] <= in_data;
        end
    end

endmodule

// File: tb/tb_pool_frame_collector.sv
// Directed bench for pool_frame_collector at default parameters (3x3 frame of 4-bit values).
module tb_pool_frame_collector;

    localparam int FW = 36;

    logic          clk = 1'b0;
    logic          res_n;
    logic          in_valid;
    logic [3:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [FW-1:0] out_data;
    logic          out_ready;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    logic [3:0] va [9] = '{4'b0111, 4'b0010, 4'b1111, 4'b1000, 4'b1000,
                           4'b1111, 4'b0010, 4'b0111, 4'b1000};
    logic [3:0] vb [9] = '{4'b0001, 4'b1001, 4'b0011, 4'b1010, 4'b0101,
                           4'b1100, 4'b0110, 4'b1110, 4'b0100};
    logic [3:0] vc [9] = '{4'b1011, 4'b0000, 4'b1101, 4'b0110, 4'b1001,
                           4'b0011, 4'b1111, 4'b0001, 4'b1010};

    pool_frame_collector dut (
        .clk       (clk),
        .res_n     (res_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] pack9(input logic [3:0] v [9]);
        logic [FW-1:0] r;
        for (int i = 0; i < 9; i++) r[i*4 +: 4] = v[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input logic [3:0] v [9]);
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data  = v[k];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_n = 1'b0; in_valid = 1'b1; in_data = 4'b0101; out_ready = 1'b1;
        tick(); tick();
        res_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset: out_valid=%b in_ready=%b overflow=%b out_data=%h, need 0 1 0 0",
                     out_valid, in_ready, overflow, out_data);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data  = va[k];
            tick();
            checks++;
            if (out_valid !== (k == 8)) begin
                failures++;
                $display("FAIL stream_valid: after value %0d out_valid=%b need %b", k, out_valid, k == 8);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_data !== pack9(va) || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stream_frame: out_data=%h in_ready=%b, need %h 0", out_data, in_ready, pack9(va));
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== pack9(va)) begin
                failures++;
                $display("FAIL hold: cycle %0d out_valid=%b out_data=%h, need 1 %h", c, out_valid, out_data, pack9(va));
            end
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_gapped();
        for (int k = 0; k < 9; k++) begin
            int bubbles = int'($urandom_range(0, 3));
            in_valid = 1'b0;
            for (int b = 0; b < bubbles; b++) begin
                tick();
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL gap_bubble: before value %0d out_valid=%b need 0", k, out_valid);
                end
            end
            in_valid = 1'b1;
            in_data  = va[k];
            tick();
            checks++;
            if (out_valid !== (k == 8)) begin
                failures++;
                $display("FAIL gap_valid: after value %0d out_valid=%b need %b", k, out_valid, k == 8);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_data !== pack9(va)) begin
            failures++;
            $display("FAIL gap_frame: out_data=%h need %h", out_data, pack9(va));
        end
    endtask

    task automatic test_overflow();
        in_valid = 1'b1;
        in_data  = 4'b0101;
        tick();
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || out_data !== pack9(va)) begin
            failures++;
            $display("FAIL overflow_drop: overflow=%b out_valid=%b out_data=%h, need 1 1 %h",
                     overflow, out_valid, out_data, pack9(va));
        end
        handshake();
        stream(vb);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pack9(vb) || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: out_valid=%b out_data=%h overflow=%b, need 1 %h 1",
                     out_valid, out_data, overflow, pack9(vb));
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = vb[k];
            tick();
        end
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_mid: overflow=%b out_valid=%b in_ready=%b out_data=%h, need 0 0 1 0",
                     overflow, out_valid, in_ready, out_data);
        end
        stream(vc);
        checks++;
        if (out_valid !== 1'b1 || out_data !== pack9(vc) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_refill: out_valid=%b out_data=%h overflow=%b, need 1 %h 0",
                     out_valid, out_data, overflow, pack9(vc));
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int   idx    = 0;
        int   frames = 0;
        logic rdy;
        logic prev_ov = 1'b0;
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && frames < 2; c++) begin
            in_valid = (idx < 18);
            in_data  = (idx < 9) ? va[idx % 9] : vb[idx % 9];
            rdy = in_ready;
            tick();
            if (rdy && in_valid) idx++;
            if (out_valid) begin
                checks++;
                if (prev_ov || out_data !== (frames == 0 ? pack9(va) : pack9(vb))) begin
                    failures++;
                    $display("FAIL b2b_frame: frame %0d prev_valid=%b out_data=%h", frames, prev_ov, out_data);
                end
                frames++;
            end
            prev_ov = out_valid;
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (frames != 2 || out_valid !== 1'b0 || overflow !== 1'b1 || idx != 18) begin
            failures++;
            $display("FAIL b2b_end: frames=%0d accepted=%0d out_valid=%b overflow=%b, need 2 18 0 1",
                     frames, idx, out_valid, overflow);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        res_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_hold();
        test_gapped();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_frame_collector.md
POOL_FRAME_COLLECTOR -- requirements
Module: pool_frame_collector

Interface
REQ-001 Parameter BitSize, default 4, width of one signed pixel value.
REQ-002 Parameter ImageWidth, default 6, side length of the image entering the upstream max pooling layer.
REQ-003 Parameter N, default 2, pooling window side and stride of the upstream layer; ImageWidth SHALL be a multiple of N.
REQ-004 Derived OutWidth = ImageWidth/N; FrameSize = OutWidth*OutWidth (default 9).
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 res_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  1  pooled value present; driven by the pooling layer's out_valid.
REQ-008 in_data  input  BitSize signed  pooled value; driven by the pooling layer's out_data.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_valid  output  1  complete pooled frame presented on out_data.
REQ-011 out_data  output  FrameSize*BitSize  packed frame; element i occupies bits [i*BitSize +: BitSize].
REQ-012 out_ready  input  1  downstream (dense layer) accepts the frame this cycle.
REQ-013 overflow  output  1  sticky flag: input was offered while not accepted.

Function
REQ-014 The block SHALL have two states, COLLECT and PRESENT; reset state is COLLECT.
REQ-015 In COLLECT, in_ready SHALL be 1 and out_valid SHALL be 0; in PRESENT, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-016 An input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; cycles with in_valid=0 SHALL change nothing.
REQ-017 The k-th accepted value of a frame (k = 0..FrameSize-1, raster order) SHALL be stored to element k.
REQ-018 A counter, width ceil(log2(FrameSize+1)), SHALL increment per transfer and wrap to 0 on the FrameSize-th transfer.
REQ-019 On the edge accepting element FrameSize-1, the state SHALL become PRESENT, so out_valid is 1 in the very next cycle (latency 1 cycle from the last input).
REQ-020 While out_valid=1, out_data SHALL be held stable until the handshake completes.
REQ-021 An output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1; on that edge the state SHALL return to COLLECT with counter 0.
REQ-022 out_ready=1 while in COLLECT SHALL have no effect.
REQ-023 Buffer contents SHALL be retained after the output transfer until overwritten; out_data is not meaningful while out_valid=0.
REQ-024 The value in_valid=1 with in_ready=0 SHALL be dropped, with no change to buffer or counter, and SHALL set overflow to 1; overflow SHALL be cleared only by reset.
REQ-025 Values are stored without arithmetic; sign and bit pattern SHALL be preserved exactly.
REQ-026 The block SHALL remain frame-aligned: no partial frame is ever presented.

Reset
REQ-027 When res_n=0 at a rising edge, the next state SHALL be: state COLLECT, counter 0, all buffer elements 0, out_valid 0, in_ready 1, overflow 0, out_data all zeros.
REQ-028 Reset SHALL take priority over any simultaneous transfer, including mid-frame and in PRESENT; the partial or pending frame SHALL be discarded.

Verification
REQ-029 Defaults: reset, then stream 9 values 0111,0010,1111,1000,1000,1111,0010,0111,1000 with in_valid=1 and out_ready=0 -> out_valid=1 from the cycle after the 9th value; elements 0..8 hold the values in that order; in_ready=0.
REQ-030 Hold out_ready=0 for 5 cycles in PRESENT, then pulse it high for 1 cycle -> out_data stays constant for all 5 cycles; one cycle after the pulse, out_valid=0, in_ready=1, and the counter is 0.
REQ-031 Gapped input: 9 values separated by random in_valid=0 bubbles -> same frame content as gapless; out_valid rises exactly one cycle after the 9th accepted value.
REQ-032 In PRESENT, drive in_valid=1 with in_data=0101 -> value not stored, frame unchanged, overflow=1 and it stays 1 after the next frames complete.
REQ-033 Reset after 4 accepted values, then stream 9 new values -> frame contains only the 9 new values; overflow=0.
REQ-034 Back-to-back: out_ready tied to 1, 18 consecutive values with in_valid=1 -> two frames presented, each out_valid for exactly one cycle; the value offered during each PRESENT cycle is dropped and sets overflow (bench holds data during that cycle to avoid loss).
